matmul_mac_engine: RTL
======================

// Module: matmul_mac_engine
// PURPOSE
// Matrix-multiply compute stage. Sits downstream of the APB slave register block: it consumes operand A/B, bias C and the control register, and produces result, overflow flags and an end-of-operation (EOP) pulse that the slave writes back into the scratchpad.
// Uses one sequential MAC per cycle: C[i][j] = bias + sum_k A[i][k]*B[k][j].
// PARAMETERS
// DATA_WIDTH  8   element bit-width (8/16/32), <= BUS_WIDTH/2
// BUS_WIDTH   32  APB data width and result-element width (16/32/64)
// MAX_DIM     BUS_WIDTH/DATA_WIDTH (localparam)  max matrix dimension
// PORTS
// clk_i          in   1                      clock
// rst_n_i        in   1                      reset, asynchronous, active-low
// control_reg_i  in   16                     [0]start [1]bias_en [9:8]N-1 [11:10]K-1 [13:12]M-1
// operand_A_i    in   BUS_WIDTH*MAX_DIM      row r at [(r+1)*BW-1:r*BW]; element e at [(e+1)*DW-1:e*DW] of the row
// operand_B_i    in   BUS_WIDTH*MAX_DIM      same packing; row k of B
// operand_C_i    in   BUS_WIDTH*MAX_DIM^2    bias; element idx=i*MAX_DIM+j, BUS_WIDTH each
// result_o       out  BUS_WIDTH*MAX_DIM^2    result, same packing as C
// ov_o           out  MAX_DIM^2              per-element signed-overflow flag
// EOP_o          out  1                      1-cycle pulse, result_o/ov_o valid
// busy_o         out  1                      high from INIT through DONE
// BEHAVIOUR
// - Reset: result_o=0, ov_o=0, EOP_o=0, busy_o=0, state=IDLE, start_d=0.
// - Start: rising edge of control_reg_i[0] (start_d is a registered copy), taken only in IDLE.
//   A level held high never retriggers; edges seen outside IDLE are ignored.
// - Dimension fields are latched in INIT. A field value >= MAX_DIM clamps to MAX_DIM-1.
// - All operands are signed two's complement. Product is 2*DW, sign-extended to BW.
//   Accumulation is BW-bit wrap-around.
// - ov: set for element (i,j) if any addition (bias add or MAC add) produces signed overflow.
//   The flag is sticky for that element within the operation.
// - FSM:
//   IDLE -> INIT on start edge.
//   INIT (1 cycle): clear result_o and ov_o, latch M/N/K/bias_en, i=j=k=0, busy_o=1.
//   LOAD (1 cycle): acc = bias_en ? C[i][j] : 0.
//   MAC (K cycles): acc += A[i][k]*B[k][j]; k++.
//   STORE (folded into the last MAC cycle): write acc to result[i*MAX_DIM+j] and update ov.
//     Then advance j, then i. Go to LOAD if elements remain, else DONE.
//   DONE (1 cycle): EOP_o=1, busy_o=0 at the next edge -> IDLE.
// - Latency: EOP_o is asserted exactly 2+M*N*(K+1) cycles after the edge that samples the start rising edge.
// - Elements outside MxN stay 0 with ov 0.
// - result_o/ov_o hold their value after DONE until the next INIT; the slave reads them over many cycles after EOP.
// - Operands must be stable while busy_o=1. The engine does not re-sample them except combinationally per MAC.
// - Reset mid-operation: immediate return to reset values; no EOP is emitted.
// STRUCTURE
// - Package matmul_pkg: control-field bit offsets (START=0, BIAS=1, N=8, K=10, M=12) and FSM state encodings.
//   Shared with the APB slave.
// - Sub-module matmul_pe: combinational signed DWxDW multiply plus BW add with overflow output.
//   Instantiated once; the engine owns the counters, acc and FSM.
// TESTING (defaults DW=8, BW=32, MAX_DIM=4)
// 1. Identity: A=[[1,0],[0,1]], B=[[3,4],[5,6]], ctrl=0x1501 -> result [0]=3 [1]=4 [4]=5 [5]=6, rest 0; EOP at cycle 14.
// 2. Signed: 1x1x1, A=0xFF(-1), B=0x7F, ctrl=0x0001 -> result[0]=0xFFFFFF81, ov=0, EOP at cycle 4.
// 3. Bias: ctrl=0x0003, C[0]=100, A=2, B=3 -> result[0]=106.
// 4. Overflow: ctrl=0x0003, C[0]=0x7FFFFFFF, A=1, B=1 -> result[0]=0x80000000, ov_o[0]=1, other ov=0.
// 5. Full 4x4x4: all A,B=0x80(-128), ctrl=0x3F01 -> every element 0x00010000; EOP at cycle 82.
//    Holding start high for 200 cycles gives exactly one EOP.
// 6. Reset at cycle 5 of test 5 -> outputs 0, no EOP, busy_o=0.
//    Drop start, then re-raise it -> test-5 results reproduced.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply engine and the APB slave that feeds it:
// control-register field offsets and the engine's FSM state encoding.
package matmul_pkg;

   localparam int CTRL_START  = 0;
   localparam int CTRL_BIAS   = 1;
   localparam int CTRL_N      = 8;
   localparam int CTRL_K      = 10;
   localparam int CTRL_M      = 12;
   localparam int DIM_FIELD_W = 2;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      LOAD,
      MAC,
      DONE
   } state_e;

endpackage

// File: rtl/matmul_pe.sv
// Single processing element: signed DWxDW multiply, sign-extended to BW and added
// to the running accumulator, with a signed-overflow flag for that addition.
module matmul_pe #(
   parameter int DATA_WIDTH = 8,
   parameter int BUS_WIDTH  = 32
) (
   input  logic signed [DATA_WIDTH-1:0] a_i,
   input  logic signed [DATA_WIDTH-1:0] b_i,
   input  logic        [BUS_WIDTH-1:0]  acc_i,
   output logic        [BUS_WIDTH-1:0]  sum_o,
   output logic                         ov_o
);

   localparam int PW = 2 * DATA_WIDTH;

   logic signed [PW-1:0]        product;
   logic signed [BUS_WIDTH-1:0] productExt;

   assign product    = PW'(a_i) * PW'(b_i);
   assign productExt = BUS_WIDTH'(product);
   assign sum_o      = acc_i + productExt;

   // Overflow only when both addends share a sign and the sum's sign differs.
   assign ov_o = (acc_i[BUS_WIDTH-1] == productExt[BUS_WIDTH-1]) &&
                 (sum_o[BUS_WIDTH-1] != acc_i[BUS_WIDTH-1]);

endmodule

// File: rtl/matmul_mac_engine.sv
// Sequential matrix-multiply engine: one MAC per cycle computes
// C[i][j] = bias + sum_k A[i][k]*B[k][j] and pulses EOP when all elements are stored.
module matmul_mac_engine
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BUS_WIDTH  = 32
) (
   input  logic                                                         clk_i,
   input  logic                                                         rst_n_i,
   input  logic [15:0]                                                  control_reg_i,
   input  logic [BUS_WIDTH*(BUS_WIDTH/DATA_WIDTH)-1:0]                  operand_A_i,
   input  logic [BUS_WIDTH*(BUS_WIDTH/DATA_WIDTH)-1:0]                  operand_B_i,
   input  logic [BUS_WIDTH*(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0] operand_C_i,
   output logic [BUS_WIDTH*(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0] result_o,
   output logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0]     ov_o,
   output logic                                                         EOP_o,
   output logic                                                         busy_o
);

   localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
   localparam int IW      = $clog2(MAX_DIM);
   localparam int NEL     = MAX_DIM * MAX_DIM;

   state_e                state_q, state_d;
   logic                  startPrev_q;
   logic                  biasEn_q;
   logic [IW-1:0]         mDim_q, nDim_q, kDim_q;
   logic [IW-1:0]         iIdx_q, jIdx_q, kIdx_q;
   logic [BUS_WIDTH-1:0]  acc_q;
   logic                  accOv_q;
   logic [BUS_WIDTH-1:0]  result_q [NEL];
   logic [NEL-1:0]        ov_q;
   logic                  eop_q;

   logic signed [DATA_WIDTH-1:0] aElem [MAX_DIM][MAX_DIM];
   logic signed [DATA_WIDTH-1:0] bElem [MAX_DIM][MAX_DIM];
   logic [BUS_WIDTH-1:0]         cElem [NEL];
   logic [2*IW-1:0]              elemIdx;
   logic [BUS_WIDTH-1:0]         peSum;
   logic                         peOv;
   logic                         startEdge, lastK, lastElem;
   logic                         ctrlUnused;

   function automatic logic [IW-1:0] clampDim(input logic [DIM_FIELD_W-1:0] field);
      logic [31:0] fieldExt;
      fieldExt = 32'(field);
      if (fieldExt >= 32'(MAX_DIM)) clampDim = IW'(MAX_DIM - 1);
      else                          clampDim = IW'(fieldExt);
   endfunction

   for (genvar r = 0; r < MAX_DIM; r++) begin : gUnpackRow
      for (genvar e = 0; e < MAX_DIM; e++) begin : gUnpackElem
         assign aElem[r][e] = operand_A_i[r*BUS_WIDTH + e*DATA_WIDTH +: DATA_WIDTH];
         assign bElem[r][e] = operand_B_i[r*BUS_WIDTH + e*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   for (genvar e = 0; e < NEL; e++) begin : gElem
      assign cElem[e]                         = operand_C_i[e*BUS_WIDTH +: BUS_WIDTH];
      assign result_o[e*BUS_WIDTH +: BUS_WIDTH] = result_q[e];
   end

   assign ov_o       = ov_q;
   assign EOP_o      = eop_q;
   assign busy_o     = (state_q != IDLE);
   assign ctrlUnused = ^{control_reg_i[15:14], control_reg_i[7:2]};

   assign startEdge = control_reg_i[CTRL_START] & ~startPrev_q;
   assign elemIdx   = {iIdx_q, jIdx_q};
   assign lastK     = (kIdx_q == kDim_q);
   assign lastElem  = (iIdx_q == mDim_q) && (jIdx_q == nDim_q);

   matmul_pe #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUS_WIDTH  (BUS_WIDTH)
   ) uPe (
      .a_i   (aElem[iIdx_q][kIdx_q]),
      .b_i   (bElem[kIdx_q][jIdx_q]),
      .acc_i (acc_q),
      .sum_o (peSum),
      .ov_o  (peOv)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (startEdge) state_d = INIT;
         INIT:    state_d = LOAD;
         LOAD:    state_d = MAC;
         MAC:     if (lastK) state_d = lastElem ? DONE : LOAD;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The store of each element is folded into its final MAC cycle, so the
   // accumulator never needs a separate write-back state.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         startPrev_q <= 1'b0;
         eop_q       <= 1'b0;
         biasEn_q    <= 1'b0;
         mDim_q      <= '0;
         nDim_q      <= '0;
         kDim_q      <= '0;
         iIdx_q      <= '0;
         jIdx_q      <= '0;
         kIdx_q      <= '0;
         acc_q       <= '0;
         accOv_q     <= 1'b0;
         ov_q        <= '0;
         for (int e = 0; e < NEL; e++) result_q[e] <= '0;
      end else begin
         startPrev_q <= control_reg_i[CTRL_START];
         eop_q       <= (state_q == DONE);
         case (state_q)
            INIT: begin
               for (int e = 0; e < NEL; e++) result_q[e] <= '0;
               ov_q     <= '0;
               mDim_q   <= clampDim(control_reg_i[CTRL_M +: DIM_FIELD_W]);
               nDim_q   <= clampDim(control_reg_i[CTRL_N +: DIM_FIELD_W]);
               kDim_q   <= clampDim(control_reg_i[CTRL_K +: DIM_FIELD_W]);
               biasEn_q <= control_reg_i[CTRL_BIAS];
               iIdx_q   <= '0;
               jIdx_q   <= '0;
               kIdx_q   <= '0;
            end
            LOAD: begin
               acc_q   <= biasEn_q ? cElem[elemIdx] : '0;
               accOv_q <= 1'b0;
               kIdx_q  <= '0;
            end
            MAC: begin
               acc_q   <= peSum;
               accOv_q <= accOv_q | peOv;
               kIdx_q  <= kIdx_q + 1'b1;
               if (lastK) begin
                  result_q[elemIdx] <= peSum;
                  ov_q[elemIdx]     <= accOv_q | peOv;
                  if (jIdx_q == nDim_q) begin
                     jIdx_q <= '0;
                     iIdx_q <= iIdx_q + 1'b1;
                  end else begin
                     jIdx_q <= jIdx_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
